// File: rtl/gl_pht_port_sched_pkg.sv
// Shared types and helpers for the gshare PHT port scheduler.
package branch_predictor;

  localparam logic [6:0] BR_OPCODE = 7'b1100011;
  localparam int PHT_IDX_W = 9;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    UPD_RD,
    UPD_WR,
    UPD_PEND
  } pht_sched_state_t;

  typedef struct packed {
    logic [PHT_IDX_W-1:0] idx;
    logic                 taken;
  } br_upd_t;

  // 2-bit saturating counter step: taken counts up, not-taken counts down.
  function automatic logic [1:0] sat2(input logic [1:0] c, input logic t);
    if (t) begin
      return (c == 2'b11) ? c : c + 2'b01;
    end else begin
      return (c == 2'b00) ? c : c - 2'b01;
    end
  endfunction

endpackage

// File: rtl/gl_pht_port_sched_br_upd_fifo.sv
// Resolved-branch update queue; entries are {idx, taken}, exposed oldest-first.
module br_upd_fifo #(
  parameter int QDEPTH = 4,
  parameter int IDX    = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [IDX:0]                 din,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [IDX:0]                 head,
  output logic [$clog2(QDEPTH):0]      count,
  output logic [QDEPTH-1:0][IDX:0]     entries,
  output logic [QDEPTH-1:0]            valid
);

  localparam int PW = $clog2(QDEPTH);

  logic [IDX:0]  r_mem [QDEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full  = (r_count == (PW+1)'(QDEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

  // A push on a full queue is accepted only when the head leaves in the same cycle.
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      entries[i] = r_mem[r_rd_ptr + PW'(i)];
      valid[i]   = ((PW+1)'(i) < r_count);
    end
  end

endmodule

// File: rtl/gl_pht_port_sched.sv
// Single-port PHT scheduler: GHR, post-reset sweep, queued RMW updates behind lookups.
// Optional BR_UPD_FORWARD_EN: lookups see the youngest queued update to the same index.
module gl_pht_port_sched
  import branch_predictor::*;
#(
  parameter int IDX    = 9,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [31:0]      pc,
  input  logic [6:0]       opcode,
  input  logic             ex_mem_br_en,
  input  logic [31:0]      ex_mem_pc,
  input  logic [6:0]       ex_mem_opcode,
  output logic             predict_dir,
  output logic             predict_valid,
  output logic             init_done,
  output logic             upd_overflow,
  output logic             pht_en,
  output logic             pht_we,
  output logic [IDX-1:0]   pht_addr,
  output logic [1:0]       pht_din,
  input  logic [1:0]       pht_dout,
  output pht_sched_state_t dbg_state
);

  localparam int PW = $clog2(QDEPTH);
`ifdef BR_UPD_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  pht_sched_state_t r_state;
  pht_sched_state_t w_next_state;

  logic [IDX-1:0] r_ghr;
  logic [IDX-1:0] r_sweep;
  logic [1:0]     r_pend_val;
  logic           r_pred_valid;
  logic           r_pred_sram;
  logic           r_fwd_hit;
  logic           r_fwd_taken;

  logic                     w_lk_req;
  logic                     w_lk_port;
  logic                     w_enq_req;
  logic [IDX-1:0]           w_lk_idx;
  logic [IDX-1:0]           w_upd_idx;
  logic                     w_sweep_last;
  logic                     w_full;
  logic                     w_empty;
  logic [IDX:0]             w_head;
  logic [IDX-1:0]           w_head_idx;
  logic                     w_head_taken;
  logic [PW:0]              w_count;
  logic [QDEPTH-1:0][IDX:0] w_entries;
  logic [QDEPTH-1:0]        w_valid;
  logic                     w_more;
  logic                     w_pop;
  logic                     w_pend_load;
  logic                     w_en;
  logic                     w_we;
  logic [IDX-1:0]           w_addr;
  logic [1:0]               w_din;
  logic                     w_fwd_hit;
  logic                     w_fwd_taken;
  logic                     w_unused;

  assign w_lk_req     = (opcode == BR_OPCODE) && !stall;
  assign w_enq_req    = (ex_mem_opcode == BR_OPCODE) && !stall;
  assign w_lk_idx     = pc[IDX+1:2] ^ r_ghr;
  assign w_upd_idx    = ex_mem_pc[IDX+1:2] ^ r_ghr;
  assign w_lk_port    = w_lk_req && (r_state != INIT);
  assign w_sweep_last = (r_sweep == {IDX{1'b1}});
  assign w_head_idx   = w_head[IDX:1];
  assign w_head_taken = w_head[0];
  // While popping, any enqueue this cycle is accepted, so it also keeps the queue busy.
  assign w_more       = (w_count > (PW+1)'(1)) || w_enq_req;
  assign w_unused     = ^{pc[31:IDX+2], pc[1:0], ex_mem_pc[31:IDX+2], ex_mem_pc[1:0]};

  br_upd_fifo #(
    .QDEPTH (QDEPTH),
    .IDX    (IDX)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_enq_req),
    .din     ({w_upd_idx, ex_mem_br_en}),
    .pop     (w_pop),
    .full    (w_full),
    .empty   (w_empty),
    .head    (w_head),
    .count   (w_count),
    .entries (w_entries),
    .valid   (w_valid)
  );

  always_comb begin
    w_next_state = r_state;
    w_en         = 1'b0;
    w_we         = 1'b0;
    w_addr       = '0;
    w_din        = '0;
    w_pop        = 1'b0;
    w_pend_load  = 1'b0;
    if (w_lk_port) begin
      w_en   = 1'b1;
      w_addr = w_lk_idx;
    end
    case (r_state)
      INIT: begin
        w_en   = 1'b1;
        w_we   = 1'b1;
        w_addr = r_sweep;
        w_din  = 2'b01;
        if (w_sweep_last) w_next_state = IDLE;
      end
      IDLE: begin
        if (!w_empty || w_enq_req) w_next_state = UPD_RD;
      end
      UPD_RD: begin
        if (!w_lk_req) begin
          w_en         = 1'b1;
          w_addr       = w_head_idx;
          w_next_state = UPD_WR;
        end
      end
      UPD_WR: begin
        // Read data is only valid this cycle, so a blocked write keeps the result.
        if (w_lk_req) begin
          w_pend_load  = 1'b1;
          w_next_state = UPD_PEND;
        end else begin
          w_en         = 1'b1;
          w_we         = 1'b1;
          w_addr       = w_head_idx;
          w_din        = sat2(pht_dout, w_head_taken);
          w_pop        = 1'b1;
          w_next_state = w_more ? UPD_RD : IDLE;
        end
      end
      UPD_PEND: begin
        if (!w_lk_req) begin
          w_en         = 1'b1;
          w_we         = 1'b1;
          w_addr       = w_head_idx;
          w_din        = r_pend_val;
          w_pop        = 1'b1;
          w_next_state = w_more ? UPD_RD : IDLE;
        end
      end
      default: w_next_state = INIT;
    endcase
  end

  // Later (younger) entries override earlier matches.
  always_comb begin
    w_fwd_hit   = 1'b0;
    w_fwd_taken = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (w_valid[i] && (w_entries[i][IDX:1] == w_lk_idx)) begin
        w_fwd_hit   = 1'b1;
        w_fwd_taken = w_entries[i][0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= INIT;
      r_sweep      <= '0;
      r_ghr        <= '0;
      r_pend_val   <= '0;
      r_pred_valid <= 1'b0;
      r_pred_sram  <= 1'b0;
      r_fwd_hit    <= 1'b0;
      r_fwd_taken  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_pred_valid <= w_lk_req;
      r_pred_sram  <= w_lk_port;
      r_fwd_hit    <= w_fwd_hit;
      r_fwd_taken  <= w_fwd_taken;
      if (r_state == INIT) r_sweep <= r_sweep + 1'b1;
      if (w_enq_req) r_ghr <= {r_ghr[IDX-2:0], ex_mem_br_en};
      if (w_pend_load) r_pend_val <= sat2(pht_dout, w_head_taken);
    end
  end

  assign predict_valid = r_pred_valid;
  assign predict_dir   = r_pred_sram & ((FWD_EN && r_fwd_hit) ? r_fwd_taken : pht_dout[1]);
  assign init_done     = (r_state != INIT);
  assign upd_overflow  = w_enq_req && w_full && !w_pop;
  // Reset holds the state in INIT; keep the sweep write off the bus until release.
  assign pht_en        = w_en & ~rst;
  assign pht_we        = w_we & ~rst;
  assign pht_addr      = rst ? '0 : w_addr;
  assign pht_din       = rst ? '0 : w_din;
  assign dbg_state     = r_state;

endmodule
